// File: rtl/comp_result_monitor.sv
// comp_result_monitor: consumes comparator flag triples over valid/ready,
// keeps saturating outcome counters and a streak tracker with a sticky alarm,
// and latches an error (stalling input) on any non-one-hot flag encoding.
module comp_result_monitor #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned STREAK_TH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             equal_to,
  input  logic             less_than,
  input  logic             greater_than,
  input  logic             clear,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] streak_len,
  output logic [1:0]       streak_kind,
  output logic             alarm,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TH      = CNT_W'(STREAK_TH);

  localparam logic [1:0] KIND_EQ = 2'b01;
  localparam logic [1:0] KIND_LT = 2'b10;
  localparam logic [1:0] KIND_GT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_ALARM = 2'b10,
    ST_ERR   = 2'b11
  } state_t;

  state_t           state;
  logic             legal;
  logic             accept;
  logic [1:0]       kind;
  logic [CNT_W-1:0] len_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Ready is a pure decode of the registered state: only ERR stalls input.
  assign in_ready = (state != ST_ERR);
  assign accept   = in_valid && in_ready;

  // Classify the offered sample and compute the streak length it would produce.
  always_comb begin
    legal    = (equal_to ^ less_than ^ greater_than) &
               ~(equal_to & less_than & greater_than);
    kind     = equal_to ? KIND_EQ : (less_than ? KIND_LT : KIND_GT);
    len_next = (streak_kind == kind) ? sat_inc(streak_len) : CNT_W'(1);
  end

  // State machine with statistics; reset outranks clear, clear outranks accept.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state       <= ST_IDLE;
      eq_count    <= '0;
      lt_count    <= '0;
      gt_count    <= '0;
      streak_len  <= '0;
      streak_kind <= 2'b00;
      alarm       <= 1'b0;
      err         <= 1'b0;
    end else if (accept) begin
      if (!legal) begin
        // Statistics frozen; alarm is deliberately left as-is.
        state <= ST_ERR;
        err   <= 1'b1;
      end else begin
        case (kind)
          KIND_EQ: eq_count <= sat_inc(eq_count);
          KIND_LT: lt_count <= sat_inc(lt_count);
          default: gt_count <= sat_inc(gt_count);
        endcase
        streak_len  <= len_next;
        streak_kind <= kind;
        if (len_next == TH) begin
          alarm <= 1'b1;
          state <= ST_ALARM;
        end else if (state == ST_ALARM) begin
          state <= ST_ALARM;
        end else begin
          state <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_comp_result_monitor.sv
// Directed + randomized bench for comp_result_monitor against a plain
// arithmetic model of the outcome statistics.
module tb_comp_result_monitor;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned STREAK_TH = 4;
  localparam int          MAXV      = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             equal_to;
  logic             less_than;
  logic             greater_than;
  logic             clear;
  logic [CNT_W-1:0] eq_count;
  logic [CNT_W-1:0] lt_count;
  logic [CNT_W-1:0] gt_count;
  logic [CNT_W-1:0] streak_len;
  logic [1:0]       streak_kind;
  logic             alarm;
  logic             err;

  int checks = 0;
  int errors = 0;

  // Reference model: counts indexed by outcome code (1 eq, 2 lt, 3 gt).
  int m_cnt [4];
  int m_len;
  int m_kind;
  bit m_alarm;
  bit m_err;

  comp_result_monitor #(
    .CNT_W     (CNT_W),
    .STREAK_TH (STREAK_TH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .equal_to     (equal_to),
    .less_than    (less_than),
    .greater_than (greater_than),
    .clear        (clear),
    .eq_count     (eq_count),
    .lt_count     (lt_count),
    .gt_count     (gt_count),
    .streak_len   (streak_len),
    .streak_kind  (streak_kind),
    .alarm        (alarm),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    m_len   = 0;
    m_kind  = 0;
    m_alarm = 1'b0;
    m_err   = 1'b0;
  endtask

  // Apply one sample to the model, following the outcome rules directly.
  task automatic model_step(input bit v, input bit e, input bit l, input bit g,
                            input bit clr, input bit rn);
    int k;
    if (!rn || clr) begin
      model_reset();
    end else if (v && !m_err) begin
      if ((int'(e) + int'(l) + int'(g)) != 1) begin
        m_err = 1'b1;
      end else begin
        k = e ? 1 : (l ? 2 : 3);
        if (m_cnt[k] < MAXV) m_cnt[k]++;
        if (k == m_kind) begin
          if (m_len < MAXV) m_len++;
        end else begin
          m_len  = 1;
          m_kind = k;
        end
        if (m_len == STREAK_TH) m_alarm = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".eq_count"},    32'(eq_count),    32'(m_cnt[1]));
    chk({tag, ".lt_count"},    32'(lt_count),    32'(m_cnt[2]));
    chk({tag, ".gt_count"},    32'(gt_count),    32'(m_cnt[3]));
    chk({tag, ".streak_len"},  32'(streak_len),  32'(m_len));
    chk({tag, ".streak_kind"}, 32'(streak_kind), 32'(m_kind));
    chk({tag, ".alarm"},       32'(alarm),       32'(m_alarm));
    chk({tag, ".err"},         32'(err),         32'(m_err));
    chk({tag, ".in_ready"},    32'(in_ready),    32'(!m_err));
  endtask

  // Drive one cycle, update the model at the edge, then sample 1 time unit later.
  task automatic cyc(input string tag, input bit v, input bit e, input bit l,
                     input bit g, input bit clr, input bit rn, input bit do_chk);
    in_valid     = v;
    equal_to     = e;
    less_than    = l;
    greater_than = g;
    clear        = clr;
    rst_n        = rn;
    @(posedge clk);
    model_step(v, e, l, g, clr, rn);
    #1;
    if (do_chk) check_all(tag);
  endtask

  task automatic smp(input string tag, input bit e, input bit l, input bit g);
    cyc(tag, 1'b1, e, l, g, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    bit [2:0] f;
    bit       v;
    bit       c;
    bit       r;
    model_reset();
    in_valid = 0; equal_to = 0; less_than = 0; greater_than = 0; clear = 0; rst_n = 0;
    #2;

    // Reset with random inputs for two edges.
    for (int i = 0; i < 2; i++) begin
      f = 3'($urandom_range(7));
      cyc("rst", 1'($urandom_range(1)), f[2], f[1], f[0], 1'($urandom_range(1)), 1'b0, 1'b1);
    end
    cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Mixed: eq (0 vs 0), gt (5 vs 2), lt (2 vs 6).
    smp("mix_eq", 1'b1, 1'b0, 1'b0);
    smp("mix_gt", 1'b0, 1'b0, 1'b1);
    smp("mix_lt", 1'b0, 1'b1, 1'b0);
    chk("mix_kind", 32'(streak_kind), 32'd2);

    // Four gt in a row raises alarm; a following eq keeps it.
    for (int i = 0; i < 4; i++) smp("gt_run", 1'b0, 1'b0, 1'b1);
    chk("alarm_set", 32'(alarm), 32'd1);
    chk("alarm_len", 32'(streak_len), 32'd4);
    smp("alarm_eq", 1'b1, 1'b0, 1'b0);
    chk("alarm_hold", 32'(alarm), 32'd1);
    chk("alarm_kind", 32'(streak_kind), 32'd1);

    // Illegal 011 stalls; later legal samples are ignored until clear.
    smp("ill", 1'b0, 1'b1, 1'b1);
    chk("ill_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) smp("ill_stall", 1'b0, 1'b1, 1'b0);
    chk("ill_eq_frozen", 32'(eq_count), 32'd2);
    cyc("ill_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_err", 32'(err), 32'd0);

    // Saturation with 300 eq samples.
    for (int i = 0; i < 300; i++) smp("sat", 1'b1, 1'b0, 1'b0);
    chk("sat_eq", 32'(eq_count), 32'd255);
    chk("sat_len", 32'(streak_len), 32'd255);

    // Clear wins over a sample in the same cycle.
    cyc("clr_vs_smp", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_vs_smp_eq", 32'(eq_count), 32'd0);

    // Reset while in ALARM.
    for (int i = 0; i < 4; i++) smp("lt_run", 1'b0, 1'b1, 1'b0);
    chk("lt_alarm", 32'(alarm), 32'd1);
    cyc("rst_mid", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_alarm", 32'(alarm), 32'd0);

    // Randomized traffic, biased toward legal one-hot flags.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(99) < 75);
      if ($urandom_range(99) < 90) f = 3'b001 << $urandom_range(2);
      else                         f = 3'($urandom_range(7));
      c = ($urandom_range(99) < 3);
      r = !($urandom_range(99) < 2);
      cyc("rnd", v, f[2], f[1], f[0], c, r, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_result_monitor.md
Name: comp_result_monitor

Overview:
- Downstream consumer of the 4-bit magnitude comparator's flag outputs (equal_to, less_than, greater_than).
- Accepts one flag triple per valid/ready handshake and keeps saturating per-outcome counters.
- Tracks the current run ("streak") of identical outcomes and raises a sticky alarm when the streak reaches a threshold.
- Detects illegal flag encodings (not exactly one flag set) and stalls until cleared.

Parameters:
CNT_W, 8, width of each outcome counter and of the streak counter
STREAK_TH, 4, streak length that triggers alarm; legal range 1 .. 2^CNT_W-1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  comparator flags present this cycle
in_ready  output  1  block can accept a sample this cycle
equal_to  input  1  comparator flag a==b
less_than  input  1  comparator flag a<b
greater_than  input  1  comparator flag a>b
clear  input  1  synchronous clear of all statistics and error/alarm state
eq_count  output  CNT_W  accepted equal outcomes, saturating
lt_count  output  CNT_W  accepted less-than outcomes, saturating
gt_count  output  CNT_W  accepted greater-than outcomes, saturating
streak_len  output  CNT_W  length of current identical-outcome run, saturating
streak_kind  output  2  outcome of current run: 00 none, 01 eq, 10 lt, 11 gt
alarm  output  1  sticky, set when streak_len reaches STREAK_TH
err  output  1  sticky, set on illegal flag encoding

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-low.
  - Priority order: rst_n low > clear > accept.
- Reset and clear:
  - When rst_n is low or clear is high at a rising edge, all counters, streak_len, alarm and err become 0.
  - streak_kind becomes 00 and the state machine goes to IDLE.
  - Any sample offered in that cycle is dropped, even if in_valid is high.
- Handshake:
  - A sample is accepted when in_valid and in_ready are both high at a rising edge.
  - in_ready is a registered-state decode: 1 in IDLE, RUN and ALARM; 0 in ERR.
  - in_ready does not depend combinationally on in_valid.
- State machine:
  - IDLE: no sample accepted since reset or clear. A legal sample moves to RUN, or to ALARM if STREAK_TH==1. An illegal sample moves to ERR.
  - RUN: a legal sample stays in RUN, or moves to ALARM when the updated streak_len equals STREAK_TH. An illegal sample moves to ERR.
  - ALARM: counting continues normally and alarm stays 1, even when the outcome changes. An illegal sample moves to ERR with alarm held at 1.
  - ERR: err=1 and no sample is accepted. Only rst_n or clear leaves this state.
- Legality check:
  - A sample is legal when exactly one of equal_to, less_than, greater_than is 1.
  - All other encodings (000, 011, 101, 110, 111) are illegal.
  - An illegal sample sets err and leaves all counters, streak_len and streak_kind unchanged.
- Counting on a legal accepted sample:
  - The matching counter increments by 1 and saturates at 2^CNT_W-1 (no wrap).
  - If streak_kind equals the new outcome, streak_len increments and saturates at 2^CNT_W-1.
  - Otherwise streak_len becomes 1 and streak_kind becomes the new outcome.
- Alarm:
  - Alarm is set on the edge where the updated streak_len equals STREAK_TH.
  - It is registered, so visible the cycle after the accepting edge.
  - It is never cleared by a streak change, only by rst_n or clear.
- Latency:
  - All outputs are registered.
  - Effects of a sample accepted at edge N are visible after edge N and stable through edge N+1.
- Idle cycles: when in_valid is low, all state is held.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs, then release -> all counts 0, streak_kind=00, alarm=0, err=0, in_ready=1.
- Mixed sequence eq(0 vs 0), gt(5 vs 2), lt(2 vs 6), one per cycle -> eq_count=1, gt_count=1, lt_count=1, streak_len=1, streak_kind=10, alarm=0.
- Alarm (STREAK_TH=4): 4 consecutive gt samples -> alarm=1 the cycle after the 4th acceptance, streak_len=4. Then one eq sample -> alarm stays 1, streak_len=1, streak_kind=01.
- Illegal encoding: flags 011 with in_valid=1 -> err=1, in_ready=0 and counts unchanged. Then 3 legal samples -> counts still unchanged. Then clear=1 -> err=0, in_ready=1, state IDLE.
- Saturation (CNT_W=8): 300 consecutive eq samples -> eq_count=255, streak_len=255, lt_count=0, gt_count=0.
- Clear versus sample: clear=1 and in_valid=1 (eq) in the same cycle -> all counts 0 and the sample is not counted.
- Reset mid-run: rst_n=0 for one edge while in ALARM -> all outputs reset after that edge.
